// File: rtl/mm_burst_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mm_burst_responder
// Purpose  : Main-memory side of the cache link. Holds a word array and
//            serves whole-block line fills (fixed latency, one beat per cycle)
//            and write-backs (beats accepted under wr_valid).
// Revision : 1.0 - initial release
// ============================================================================
module mm_burst_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_write,
  input  logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0]  req_block,
  input  logic [DATA_W-1:0]                      wr_data,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  output logic [DATA_W-1:0]                      rd_data,
  output logic                                   rd_valid,
  output logic                                   done,
  output logic                                   busy
);

  localparam int c_BEAT_W = $clog2(BLOCK_WORDS);
  localparam int c_BLK_W  = ADDR_W - c_BEAT_W;
  localparam int c_DEPTH  = 1 << ADDR_W;
  localparam int c_LAT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_LAT_W-1:0]   r_lat, w_lat_nxt;
  logic [c_BEAT_W-1:0]  r_beat, w_beat_nxt;
  logic [c_BLK_W-1:0]   r_blk, w_blk_nxt;
  logic                 r_write, w_write_nxt;
  logic [DATA_W-1:0]    r_rd_data, w_rd_data_nxt;
  logic                 r_rd_valid, w_rd_valid_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_mem_we;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    r_mem [c_DEPTH];

  // The beat counter only spans the block offset, so a burst can never leave its block.
  assign w_addr = {r_blk, r_beat};

  assign req_ready = (r_state == S_IDLE);
  assign wr_ready  = (r_state == S_WRITE);
  assign busy      = (r_state != S_IDLE);
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;

  // Next-state, counter and output-register logic for the transfer FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_lat_nxt      = r_lat;
    w_beat_nxt     = r_beat;
    w_blk_nxt      = r_blk;
    w_write_nxt    = r_write;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_blk_nxt   = req_block;
          w_write_nxt = req_write;
          w_lat_nxt   = c_LAT_W'(LATENCY);
          w_beat_nxt  = '0;
          if (LATENCY == 0) begin
            w_state_nxt = req_write ? S_WRITE : S_READ;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_lat_nxt = r_lat - c_LAT_W'(1);
        if (r_lat == c_LAT_W'(1)) begin
          w_state_nxt = r_write ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        w_rd_data_nxt  = r_mem[w_addr];
        w_rd_valid_nxt = 1'b1;
        w_beat_nxt     = r_beat + c_BEAT_W'(1);
        if (r_beat == c_LAST_BEAT) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          w_mem_we   = 1'b1;
          w_beat_nxt = r_beat + c_BEAT_W'(1);
          if (r_beat == c_LAST_BEAT) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, captured request and registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lat      <= '0;
      r_beat     <= '0;
      r_blk      <= '0;
      r_write    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat      <= w_lat_nxt;
      r_beat     <= w_beat_nxt;
      r_blk      <= w_blk_nxt;
      r_write    <= w_write_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Word array; reset clears every word so memory contents are deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[w_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_burst_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mm_burst_responder
// Purpose  : Scoreboard bench for mm_burst_responder. Stimulus pushes expected
//            beats/done pulses (value and cycle); a negedge monitor pops them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_burst_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_block;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        busy;

  mm_burst_responder #(
    .ADDR_W(5), .DATA_W(16), .BLOCK_WORDS(4), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_block(req_block),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy)
  );

  typedef struct {
    bit          rd;
    logic [15:0] data;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] tb_mem [32];
  logic [15:0] wd [4];
  int          cyc;
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every beat or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid || done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output rd_valid=%0b done=%0b data=0x%0h required=none (cycle %0d)",
                   rd_valid, done, rd_data, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("beat_is_read", {31'd0, rd_valid}, {31'd0, mon_e.rd});
          if (mon_e.rd) chk("rd_data", {16'd0, rd_data}, {16'd0, mon_e.data});
          chk("done_flag", {31'd0, done}, {31'd0, mon_e.last});
          chk("beat_cycle", cyc, mon_e.cyc);
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_output actual=none required_at_cycle=%0d (cycle %0d)", mon_e.cyc, cyc);
      end
    end
  end

  task automatic wait_req_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL timeout_req_ready actual=0 required=1");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout_idle busy actual=1 required=0");
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue_req(input bit wr, input logic [2:0] blk, output int acc);
    wait_req_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_block = blk;
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic push_read(input logic [2:0] blk, input int acc);
    for (int k = 0; k < 4; k++) begin
      q.push_back('{rd: 1'b1, data: tb_mem[int'(blk) * 4 + k], last: (k == 3), cyc: acc + LAT + 1 + k});
    end
  endtask

  task automatic read_block(input logic [2:0] blk);
    int acc;
    issue_req(1'b0, blk, acc);
    push_read(blk, acc);
    @(negedge clk);
    wait_idle();
  endtask

  // Writes wd[0..3]; wr_valid is dropped for gap_len cycles before beat gap_at.
  task automatic write_block(input logic [2:0] blk, input int gap_at, input int gap_len);
    int acc;
    int n = 0;
    issue_req(1'b1, blk, acc);
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_cycle", cyc, acc + LAT);
    for (int b = 0; b < 4; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          wr_valid = 1'b0;
          @(negedge clk);
          chk("wr_ready_in_gap", {31'd0, wr_ready}, 32'd1);
        end
      end
      wr_valid = 1'b1;
      wr_data  = wd[b];
      tb_mem[int'(blk) * 4 + b] = wd[b];
      if (b == 3) q.push_back('{rd: 1'b0, data: 16'h0, last: 1'b1, cyc: cyc + 1});
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int acc;
    int acc2;
    int n;
    checks = 0;
    errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_block = 3'd0;
    wr_data = 16'h0;
    wr_valid = 1'b0;
    for (int i = 0; i < 32; i++) tb_mem[i] = 16'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: read of untouched block 5 returns zeros
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    read_block(3'd5);

    // 2: continuous write of block 2, then read it back
    wd = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    write_block(3'd2, 4, 0);
    read_block(3'd2);

    // 3: write block 3 with a 3-cycle wr_valid gap after beat 1
    wd = '{16'h3A01, 16'h3A02, 16'h3A03, 16'h3A04};
    write_block(3'd3, 2, 3);
    read_block(3'd3);

    // 4: read block 1 while block 6 is requested during WAIT/READ
    wd = '{16'h0101, 16'h0102, 16'h0103, 16'h0104};
    write_block(3'd1, 4, 0);
    wd = '{16'h0606, 16'h0607, 16'h0608, 16'h0609};
    write_block(3'd6, 4, 0);
    wait_req_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_block = 3'd1;
    @(negedge clk);
    acc = cyc;
    push_read(3'd1, acc);
    req_block = 3'd6;
    for (int i = 0; i < 6; i++) begin
      chk("req_ready_while_busy", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_after_ignored_req", {31'd0, busy}, 32'd0);

    // 5: block 7 boundary, then back-to-back read of block 0
    wd = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    write_block(3'd7, 4, 0);
    wait_req_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_block = 3'd7;
    @(negedge clk);
    acc = cyc;
    push_read(3'd7, acc);
    req_block = 3'd0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_cycle", cyc, acc + LAT + 4);
    @(negedge clk);
    acc2 = cyc;
    req_valid = 1'b0;
    push_read(3'd0, acc2);
    @(negedge clk);
    wait_idle();

    // 6: asynchronous reset in the middle of a write to block 4
    issue_req(1'b1, 3'd4, acc);
    n = 0;
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b1;
    wr_data = 16'h4444;
    @(negedge clk);
    wr_data = 16'h4445;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("async_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_rd_data", {16'd0, rd_data}, 32'd0);
    wr_valid = 1'b0;
    for (int i = 0; i < 32; i++) tb_mem[i] = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_block(3'd4);
    read_block(3'd2);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
